// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and
// helpers that give the first and last swept index for a given direction.
package tts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index the sweep starts from.
    function automatic int unsigned first_idx(input int unsigned n_in, input bit descend);
        return descend ? ((32'd1 << n_in) - 32'd1) : 32'd0;
    endfunction

    // Index whose transfer ends the sweep.
    function automatic int unsigned last_idx(input int unsigned n_in, input bit descend);
        return descend ? 32'd0 : ((32'd1 << n_in) - 32'd1);
    endfunction

endpackage

// File: rtl/tt_bit_select.sv
// TT_W:1 bit multiplexer: returns entry idx of a 2**N_IN-bit truth table.
module tt_bit_select
    import tts_pkg::*;
#(
    parameter  int N_IN = 3,
    localparam int TT_W = 2 ** N_IN
) (
    input  logic [TT_W-1:0] tbl,
    input  logic [N_IN-1:0] idx,
    output logic            bit_o
);

    assign bit_o = tbl[idx];

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: captures a 2**N_IN-bit function table on start, then
// streams every (input vector, f(vector)) pair over a valid/ready handshake
// while counting minterms. Sweep direction is set by DESCEND.
// Optional build macro SWEEP_CHECK_EN adds an expected-table comparison with
// per-pair mismatch flag, error counter and a pass flag.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter  int N_IN    = 3,
    parameter  int DESCEND = 0,
    localparam int TT_W    = 2 ** N_IN,
    localparam int CNT_W   = N_IN + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [TT_W-1:0]  tt,
`ifdef SWEEP_CHECK_EN
    input  logic [TT_W-1:0]  exp_tt,
`endif
    input  logic             out_ready,
    output logic             out_valid,
    output logic [N_IN-1:0]  out_idx,
    output logic             out_s,
    output logic             busy,
    output logic             done,
`ifdef SWEEP_CHECK_EN
    output logic             out_mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic             pass,
`endif
    output logic [CNT_W-1:0] ones_cnt
);

    localparam int unsigned   FIRST_I  = first_idx(N_IN, DESCEND != 0);
    localparam int unsigned   LAST_I   = last_idx(N_IN, DESCEND != 0);
    localparam logic [N_IN-1:0] FIRST_IDX = FIRST_I[N_IN-1:0];
    localparam logic [N_IN-1:0] LAST_IDX  = LAST_I[N_IN-1:0];

    state_t            state_q, state_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  ones_cnt_q, ones_cnt_d;
    logic              sel_bit;
    logic              accept;

`ifdef SWEEP_CHECK_EN
    logic [TT_W-1:0]   exp_tt_q, exp_tt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              pass_q, pass_d;
    logic              exp_bit;
    logic              mismatch;
`endif

    // f(idx) comes only from registered state, so no input reaches out_s.
    tt_bit_select #(.N_IN(N_IN)) u_sel_f (
        .tbl   (tt_q),
        .idx   (idx_q),
        .bit_o (sel_bit)
    );

`ifdef SWEEP_CHECK_EN
    tt_bit_select #(.N_IN(N_IN)) u_sel_exp (
        .tbl   (exp_tt_q),
        .idx   (idx_q),
        .bit_o (exp_bit)
    );
    assign mismatch     = sel_bit ^ exp_bit;
    assign out_mismatch = mismatch & (state_q == ST_RUN);
    assign err_cnt      = err_cnt_q;
    assign pass         = pass_q;
`endif

    assign out_valid = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign out_idx   = idx_q;
    assign out_s     = sel_bit;
    assign ones_cnt  = ones_cnt_q;

    // Next-state logic: advance on each transfer, restart from IDLE or DONE.
    always_comb begin
        state_d    = state_q;
        tt_d       = tt_q;
        idx_d      = idx_q;
        ones_cnt_d = ones_cnt_q;
`ifdef SWEEP_CHECK_EN
        exp_tt_d   = exp_tt_q;
        err_cnt_d  = err_cnt_q;
        pass_d     = pass_q;
`endif
        accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (out_ready) begin
                    ones_cnt_d = ones_cnt_q + CNT_W'(sel_bit);
`ifdef SWEEP_CHECK_EN
                    err_cnt_d  = err_cnt_q + CNT_W'(mismatch);
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
`ifdef SWEEP_CHECK_EN
                        pass_d  = (err_cnt_d == '0);
`endif
                    end else if (DESCEND != 0) begin
                        idx_d = idx_q - N_IN'(1);
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A start seen in IDLE or in the single DONE cycle loads a fresh sweep.
        if (accept) begin
            state_d    = ST_RUN;
            tt_d       = tt;
            idx_d      = FIRST_IDX;
            ones_cnt_d = '0;
`ifdef SWEEP_CHECK_EN
            exp_tt_d   = exp_tt;
            err_cnt_d  = '0;
            pass_d     = 1'b0;
`endif
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tt_q       <= '0;
            idx_q      <= '0;
            ones_cnt_q <= '0;
`ifdef SWEEP_CHECK_EN
            exp_tt_q   <= '0;
            err_cnt_q  <= '0;
            pass_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tt_q       <= tt_d;
            idx_q      <= idx_d;
            ones_cnt_q <= ones_cnt_d;
`ifdef SWEEP_CHECK_EN
            exp_tt_q   <= exp_tt_d;
            err_cnt_q  <= err_cnt_d;
            pass_q     <= pass_d;
`endif
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: an ascending (unit 0) and a descending
// (unit 1) instance driven with directed and random tables and random
// backpressure, compared against a list-based model of the sweep.
module tb_truth_table_sweeper;

    localparam int N_IN = 3;
    localparam int TT_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic            start_s [2];
    logic [TT_W-1:0] tt_s    [2];
    logic            rdy_s   [2];
    logic            vld_s   [2];
    logic [N_IN-1:0] idx_s   [2];
    logic            s_s     [2];
    logic            busy_s  [2];
    logic            done_s  [2];
    logic [N_IN:0]   cnt_s   [2];
`ifdef SWEEP_CHECK_EN
    logic [TT_W-1:0] exp_s   [2];
    logic            mm_s    [2];
    logic [N_IN:0]   err_s   [2];
    logic            pass_s  [2];
`endif

    int checks = 0;
    int errors = 0;

    truth_table_sweeper #(.N_IN(N_IN), .DESCEND(0)) dut_asc (
        .clk          (clk),
        .reset        (reset),
        .start        (start_s[0]),
        .tt           (tt_s[0]),
`ifdef SWEEP_CHECK_EN
        .exp_tt       (exp_s[0]),
`endif
        .out_ready    (rdy_s[0]),
        .out_valid    (vld_s[0]),
        .out_idx      (idx_s[0]),
        .out_s        (s_s[0]),
        .busy         (busy_s[0]),
        .done         (done_s[0]),
`ifdef SWEEP_CHECK_EN
        .out_mismatch (mm_s[0]),
        .err_cnt      (err_s[0]),
        .pass         (pass_s[0]),
`endif
        .ones_cnt     (cnt_s[0])
    );

    truth_table_sweeper #(.N_IN(N_IN), .DESCEND(1)) dut_desc (
        .clk          (clk),
        .reset        (reset),
        .start        (start_s[1]),
        .tt           (tt_s[1]),
`ifdef SWEEP_CHECK_EN
        .exp_tt       (exp_s[1]),
`endif
        .out_ready    (rdy_s[1]),
        .out_valid    (vld_s[1]),
        .out_idx      (idx_s[1]),
        .out_s        (s_s[1]),
        .busy         (busy_s[1]),
        .done         (done_s[1]),
`ifdef SWEEP_CHECK_EN
        .out_mismatch (mm_s[1]),
        .err_cnt      (err_s[1]),
        .pass         (pass_s[1]),
`endif
        .ones_cnt     (cnt_s[1])
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high; 1: 1,0,0,1 pattern plus 3-cycle stall at idx 4; 2: random
    task automatic run_sweep(input int u, input logic [TT_W-1:0] tbl,
                             input logic [TT_W-1:0] etbl, input int mode);
        int            order[$];
        int            got_n;
        int            ones_model;
        int            errs_model;
        int            cyc;
        int            stall4;
        bit            finished;
        bit            r;
        bit            prev_stall;
        logic [N_IN-1:0] prev_idx;
        logic          prev_s;
        logic [N_IN:0] prev_cnt;
        int            e;

        for (int k = 0; k < TT_W; k++) order.push_back((u == 1) ? (TT_W - 1 - k) : k);
        got_n = 0; ones_model = 0; errs_model = 0; stall4 = 0;
        finished = 1'b0; prev_stall = 1'b0;
        prev_idx = '0; prev_s = 1'b0; prev_cnt = '0;

        @(negedge clk);
        tt_s[u] = tbl;
`ifdef SWEEP_CHECK_EN
        exp_s[u] = etbl;
`else
        if (etbl === 'x) tt_s[u] = tbl;
`endif
        start_s[u] = 1'b1;
        rdy_s[u] = 1'b0;
        @(negedge clk);
        start_s[u] = 1'b0;
        cyc = 1;

        while (cyc < 500 && !finished) begin
            if (done_s[u]) begin
                finished = 1'b1;
                start_s[u] = 1'b0;
                chk_val($sformatf("u%0d transfers", u), got_n, TT_W);
                chk_val($sformatf("u%0d ones_at_done", u), cnt_s[u], $countones(tbl));
                chk_val($sformatf("u%0d valid_in_done", u), vld_s[u], 0);
                if (mode == 0) chk_val($sformatf("u%0d done_cycle", u), cyc, TT_W + 1);
`ifdef SWEEP_CHECK_EN
                chk_val($sformatf("u%0d err_cnt", u), err_s[u], errs_model);
                chk_val($sformatf("u%0d pass", u), pass_s[u], (errs_model == 0));
`endif
            end else begin
                // Junk on tt and random start pulses must not disturb a running sweep.
                tt_s[u] = TT_W'($urandom);
                start_s[u] = 1'($urandom_range(0, 1));
                case (mode)
                    0: r = 1'b1;
                    1: begin
                        r = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                        if (vld_s[u] && idx_s[u] == 3'd4 && stall4 < 3) begin
                            r = 1'b0;
                            stall4++;
                        end
                    end
                    default: r = ($urandom_range(0, 9) < 7);
                endcase
                rdy_s[u] = r;
                chk_val($sformatf("u%0d valid c%0d", u, cyc), vld_s[u], 1);
                chk_val($sformatf("u%0d busy c%0d", u, cyc), busy_s[u], 1);
                chk_val($sformatf("u%0d s_vs_table c%0d", u, cyc), s_s[u], tbl[idx_s[u]]);
                chk_val($sformatf("u%0d running_ones c%0d", u, cyc), cnt_s[u], ones_model);
`ifdef SWEEP_CHECK_EN
                chk_val($sformatf("u%0d mismatch c%0d", u, cyc), mm_s[u], (tbl[idx_s[u]] != etbl[idx_s[u]]));
`endif
                if (prev_stall) begin
                    chk_val($sformatf("u%0d stall_idx c%0d", u, cyc), idx_s[u], prev_idx);
                    chk_val($sformatf("u%0d stall_s c%0d", u, cyc), s_s[u], prev_s);
                    chk_val($sformatf("u%0d stall_cnt c%0d", u, cyc), cnt_s[u], prev_cnt);
                end
                if (r) begin
                    if (got_n < TT_W) begin
                        e = order[got_n];
                        chk_val($sformatf("u%0d order k%0d", u, got_n), idx_s[u], e);
                        chk_val($sformatf("u%0d s k%0d", u, got_n), s_s[u], tbl[e]);
                        ones_model += int'(tbl[e]);
                        if (tbl[e] != etbl[e]) errs_model++;
                    end else begin
                        chk_val($sformatf("u%0d extra_transfer", u), got_n, TT_W - 1);
                    end
                    got_n++;
                end
                prev_stall = !r;
                prev_idx = idx_s[u];
                prev_s = s_s[u];
                prev_cnt = cnt_s[u];
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) chk_val($sformatf("u%0d timeout", u), 0, 1);
        start_s[u] = 1'b0;
        rdy_s[u] = 1'b0;
        @(negedge clk);
        chk_val($sformatf("u%0d idle_valid", u), vld_s[u], 0);
        chk_val($sformatf("u%0d idle_busy", u), busy_s[u], 0);
        chk_val($sformatf("u%0d idle_done", u), done_s[u], 0);
        chk_val($sformatf("u%0d idle_ones_hold", u), cnt_s[u], $countones(tbl));
    endtask

    task automatic reset_abort_test();
        int guard;
        @(negedge clk);
        tt_s[0] = 8'hAE;
        start_s[0] = 1'b1;
        rdy_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        guard = 0;
        while (!(vld_s[0] && idx_s[0] == 3'd3) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk_val("abort_reached_idx3", guard < 20, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_val("abort_valid", vld_s[0], 0);
        chk_val("abort_busy", busy_s[0], 0);
        chk_val("abort_ones", cnt_s[0], 0);
        chk_val("abort_done", done_s[0], 0);
        rdy_s[0] = 1'b0;
        @(negedge clk);
        chk_val("abort_no_done_later", done_s[0], 0);
        chk_val("abort_stays_idle", vld_s[0], 0);
    endtask

    task automatic back_to_back_test();
        int pos;
        @(negedge clk);
        tt_s[0] = 8'hFF;
`ifdef SWEEP_CHECK_EN
        exp_s[0] = 8'hFF;
`endif
        start_s[0] = 1'b1;
        rdy_s[0] = 1'b1;
        for (int c = 1; c <= 2 * (TT_W + 1); c++) begin
            @(negedge clk);
            pos = (c - 1) % (TT_W + 1);
            chk_val($sformatf("b2b valid c%0d", c), vld_s[0], (pos < TT_W));
            chk_val($sformatf("b2b done c%0d", c), done_s[0], (pos == TT_W));
            if (pos < TT_W) chk_val($sformatf("b2b idx c%0d", c), idx_s[0], pos);
            if (pos == TT_W) chk_val($sformatf("b2b ones c%0d", c), cnt_s[0], TT_W);
            if (c == 2 * (TT_W + 1)) start_s[0] = 1'b0;
        end
        @(negedge clk);
        chk_val("b2b end_valid", vld_s[0], 0);
        chk_val("b2b end_done", done_s[0], 0);
        rdy_s[0] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0;
            tt_s[u] = '0;
            rdy_s[u] = 1'b0;
`ifdef SWEEP_CHECK_EN
            exp_s[u] = '0;
`endif
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk_val($sformatf("rst u%0d valid", u), vld_s[u], 0);
            chk_val($sformatf("rst u%0d busy", u), busy_s[u], 0);
            chk_val($sformatf("rst u%0d done", u), done_s[u], 0);
            chk_val($sformatf("rst u%0d ones", u), cnt_s[u], 0);
            chk_val($sformatf("rst u%0d idx", u), idx_s[u], 0);
            chk_val($sformatf("rst u%0d s", u), s_s[u], 0);
`ifdef SWEEP_CHECK_EN
            chk_val($sformatf("rst u%0d err", u), err_s[u], 0);
            chk_val($sformatf("rst u%0d pass", u), pass_s[u], 0);
`endif
        end
        reset = 1'b0;

        run_sweep(0, 8'hAE, 8'hAF, 0);
        run_sweep(0, 8'hAE, 8'hAE, 1);
        run_sweep(1, 8'h01, 8'h01, 0);
        for (int n = 0; n < 3; n++) begin
            run_sweep(0, 8'($urandom), 8'($urandom), 2);
            run_sweep(1, 8'($urandom), 8'($urandom), 2);
        end
        reset_abort_test();
        run_sweep(0, 8'hAE, 8'hAE, 0);
        back_to_back_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
